// File: rtl/axil_reg_responder.sv
// AXI4-Lite slave register file: NUM_REGS x 32-bit window at BASE_ADDR with a
// read-only ID register at index 0, byte-strobed writes and per-register write pulses.
module axil_reg_responder #(
   parameter int unsigned                  S_AXI_ADDR_WIDTH = 32,
   parameter int unsigned                  NUM_REGS         = 16,
   parameter logic [S_AXI_ADDR_WIDTH-1:0]  BASE_ADDR        = '0,
   parameter logic [31:0]                  ID_VALUE         = 32'h5A11_0001
) (
   input  logic                         s_axi_aclk,
   input  logic                         s_axi_areset,
   input  logic [S_AXI_ADDR_WIDTH-1:0]  s_axi_awaddr,
   input  logic [2:0]                   s_axi_awprot,
   input  logic                         s_axi_awvalid,
   output logic                         s_axi_awready,
   input  logic [31:0]                  s_axi_wdata,
   input  logic [3:0]                   s_axi_wstrb,
   input  logic                         s_axi_wvalid,
   output logic                         s_axi_wready,
   output logic [1:0]                   s_axi_bresp,
   output logic                         s_axi_bvalid,
   input  logic                         s_axi_bready,
   input  logic [S_AXI_ADDR_WIDTH-1:0]  s_axi_araddr,
   input  logic [2:0]                   s_axi_arprot,
   input  logic                         s_axi_arvalid,
   output logic                         s_axi_arready,
   output logic [31:0]                  s_axi_rdata,
   output logic [1:0]                   s_axi_rresp,
   output logic                         s_axi_rvalid,
   input  logic                         s_axi_rready,
   output logic [NUM_REGS*32-1:0]       reg_q,
   output logic [NUM_REGS-1:0]          reg_wr_pulse
);

   localparam int unsigned AW    = S_AXI_ADDR_WIDTH;
   localparam int unsigned IDX_W = $clog2(NUM_REGS);

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic { W_COLLECT, W_RESP } w_state_t;
   typedef enum logic { R_IDLE, R_RESP } r_state_t;

   function automatic logic in_window(input logic [AW-1:0] a);
      return a[AW-1:IDX_W+2] == BASE_ADDR[AW-1:IDX_W+2];
   endfunction

   w_state_t           w_state_q, w_state_n;
   logic               aw_held_q, aw_held_n;
   logic               w_held_q, w_held_n;
   logic [AW-1:0]      aw_addr_q, aw_addr_n;
   logic [31:0]        wdata_q, wdata_n;
   logic [3:0]         wstrb_q, wstrb_n;
   logic               awready_q, awready_n;
   logic               wready_q, wready_n;
   logic               bvalid_q, bvalid_n;
   logic [1:0]         bresp_q, bresp_n;
   logic [NUM_REGS-1:0] pulse_q, pulse_n;
   logic [31:0]        regs_q [NUM_REGS];
   logic [31:0]        regs_n [NUM_REGS];

   r_state_t           r_state_q, r_state_n;
   logic               arready_q, arready_n;
   logic               rvalid_q, rvalid_n;
   logic [1:0]         rresp_q, rresp_n;
   logic [31:0]        rdata_q, rdata_n;

   logic [IDX_W-1:0]   widx;
   logic [IDX_W-1:0]   ridx;

   assign widx = aw_addr_q[IDX_W+1:2];
   assign ridx = s_axi_araddr[IDX_W+1:2];

   // State register for both channels and the register array
   always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
      if (s_axi_areset) begin
         w_state_q <= W_COLLECT;
         aw_held_q <= 1'b0;
         w_held_q  <= 1'b0;
         aw_addr_q <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= '0;
         pulse_q   <= '0;
         regs_q    <= '{default: '0};
         r_state_q <= R_IDLE;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rresp_q   <= '0;
         rdata_q   <= '0;
      end else begin
         w_state_q <= w_state_n;
         aw_held_q <= aw_held_n;
         w_held_q  <= w_held_n;
         aw_addr_q <= aw_addr_n;
         wdata_q   <= wdata_n;
         wstrb_q   <= wstrb_n;
         awready_q <= awready_n;
         wready_q  <= wready_n;
         bvalid_q  <= bvalid_n;
         bresp_q   <= bresp_n;
         pulse_q   <= pulse_n;
         regs_q    <= regs_n;
         r_state_q <= r_state_n;
         arready_q <= arready_n;
         rvalid_q  <= rvalid_n;
         rresp_q   <= rresp_n;
         rdata_q   <= rdata_n;
      end
   end

   // Write path: collect AW and W independently, commit once both are held
   always_comb begin
      w_state_n = w_state_q;
      aw_held_n = aw_held_q;
      w_held_n  = w_held_q;
      aw_addr_n = aw_addr_q;
      wdata_n   = wdata_q;
      wstrb_n   = wstrb_q;
      awready_n = awready_q;
      wready_n  = wready_q;
      bvalid_n  = bvalid_q;
      bresp_n   = bresp_q;
      pulse_n   = '0;
      regs_n    = regs_q;
      case (w_state_q)
         W_COLLECT: begin
            if (aw_held_q && w_held_q) begin
               w_state_n = W_RESP;
               bvalid_n  = 1'b1;
               awready_n = 1'b0;
               wready_n  = 1'b0;
               aw_held_n = 1'b0;
               w_held_n  = 1'b0;
               if (!in_window(aw_addr_q)) begin
                  bresp_n = RESP_DECERR;
               end else if (widx == '0) begin
                  bresp_n = RESP_SLVERR;
               end else begin
                  bresp_n       = RESP_OKAY;
                  pulse_n[widx] = 1'b1;
                  for (int k = 0; k < 4; k++) begin
                     if (wstrb_q[k]) regs_n[widx][8*k +: 8] = wdata_q[8*k +: 8];
                  end
               end
            end else begin
               if (s_axi_awvalid && awready_q) begin
                  aw_held_n = 1'b1;
                  aw_addr_n = s_axi_awaddr;
               end
               if (s_axi_wvalid && wready_q) begin
                  w_held_n = 1'b1;
                  wdata_n  = s_axi_wdata;
                  wstrb_n  = s_axi_wstrb;
               end
               awready_n = !aw_held_n;
               wready_n  = !w_held_n;
            end
         end
         W_RESP: begin
            if (s_axi_bready) begin
               w_state_n = W_COLLECT;
               bvalid_n  = 1'b0;
               awready_n = 1'b1;
               wready_n  = 1'b1;
            end
         end
      endcase
   end

   // Read path: data sampled from the pre-commit register values at the AR edge
   always_comb begin
      r_state_n = r_state_q;
      arready_n = arready_q;
      rvalid_n  = rvalid_q;
      rresp_n   = rresp_q;
      rdata_n   = rdata_q;
      case (r_state_q)
         R_IDLE: begin
            arready_n = 1'b1;
            if (s_axi_arvalid && arready_q) begin
               r_state_n = R_RESP;
               arready_n = 1'b0;
               rvalid_n  = 1'b1;
               if (!in_window(s_axi_araddr)) begin
                  rdata_n = '0;
                  rresp_n = RESP_DECERR;
               end else if (ridx == '0) begin
                  rdata_n = ID_VALUE;
                  rresp_n = RESP_OKAY;
               end else begin
                  rdata_n = regs_q[ridx];
                  rresp_n = RESP_OKAY;
               end
            end
         end
         R_RESP: begin
            if (s_axi_rready) begin
               r_state_n = R_IDLE;
               rvalid_n  = 1'b0;
               arready_n = 1'b1;
            end
         end
      endcase
   end

   always_comb begin
      reg_q[31:0] = ID_VALUE;
      for (int i = 1; i < NUM_REGS; i++) reg_q[32*i +: 32] = regs_q[i];
   end

   assign s_axi_awready = awready_q;
   assign s_axi_wready  = wready_q;
   assign s_axi_bvalid  = bvalid_q;
   assign s_axi_bresp   = bresp_q;
   assign s_axi_arready = arready_q;
   assign s_axi_rvalid  = rvalid_q;
   assign s_axi_rresp   = rresp_q;
   assign s_axi_rdata   = rdata_q;
   assign reg_wr_pulse  = pulse_q;

   logic unused_ok;
   assign unused_ok = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0],
                        aw_addr_q[1:0], regs_q[0]};

endmodule

// File: tb/tb_axil_reg_responder.sv
// Randomized bench for axil_reg_responder against a transaction-level register model.
module tb_axil_reg_responder;

   localparam int unsigned AW   = 32;
   localparam int unsigned NR   = 16;
   localparam int unsigned RW   = NR * 32;
   localparam logic [31:0] BASE = 32'h0000_0000;
   localparam logic [31:0] IDV  = 32'h5A11_0001;

   logic          clk = 1'b0;
   logic          rst;
   logic [AW-1:0] awaddr, araddr;
   logic [2:0]    awprot, arprot;
   logic          awvalid, awready, wvalid, wready, bvalid, bready;
   logic          arvalid, arready, rvalid, rready;
   logic [31:0]   wdata, rdata;
   logic [3:0]    wstrb;
   logic [1:0]    bresp, rresp;
   logic [RW-1:0] reg_q;
   logic [NR-1:0] reg_wr_pulse;

   axil_reg_responder #(
      .S_AXI_ADDR_WIDTH(AW), .NUM_REGS(NR), .BASE_ADDR(BASE), .ID_VALUE(IDV)
   ) dut (
      .s_axi_aclk(clk), .s_axi_areset(rst),
      .s_axi_awaddr(awaddr), .s_axi_awprot(awprot), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
      .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
      .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
      .s_axi_araddr(araddr), .s_axi_arprot(arprot), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
      .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
      .reg_q(reg_q), .reg_wr_pulse(reg_wr_pulse)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
   } wr_t;

   wr_t         wq[$];
   logic [31:0] rq[$];
   logic [31:0] model [NR];
   int          n_chk  = 0;
   int          n_pass = 0;

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic chkw(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   function automatic logic in_win(input logic [31:0] a);
      return (a - BASE) < 32'(NR * 4);
   endfunction

   function automatic int idx_of(input logic [31:0] a);
      return int'((a - BASE) >> 2);
   endfunction

   function automatic logic [RW-1:0] model_flat();
      logic [RW-1:0] f;
      f[31:0] = IDV;
      for (int i = 1; i < NR; i++) f[32*i +: 32] = model[i];
      return f;
   endfunction

   // Per-cycle compare against the model; reads resolve before a same-edge write commit
   logic          prev_b, prev_r;
   logic [1:0]    exp_bresp, exp_rresp;
   logic [31:0]   exp_rdata, ra;
   logic [NR-1:0] exp_pulse;
   wr_t           cw;
   int            ix;

   always @(negedge clk) begin
      if (rst) begin
         wq.delete();
         rq.delete();
         for (int i = 0; i < NR; i++) model[i] = '0;
         prev_b = 1'b0;
         prev_r = 1'b0;
         chk32("rst_bvalid", 32'(bvalid), 32'd0);
         chk32("rst_rvalid", 32'(rvalid), 32'd0);
         chk32("rst_readies", 32'({awready, wready, arready}), 32'd0);
         chk32("rst_rdata", rdata, 32'd0);
         chk32("rst_resps", 32'({bresp, rresp}), 32'd0);
         chk32("rst_pulse", 32'(reg_wr_pulse), 32'd0);
         chkw("rst_reg_q", reg_q, RW'(IDV));
      end else begin
         exp_pulse = '0;
         if (rvalid && !prev_r) begin
            chk32("r_has_request", 32'(rq.size() > 0), 32'd1);
            if (rq.size() > 0) begin
               ra = rq.pop_front();
               if (!in_win(ra)) begin
                  exp_rdata = '0;  exp_rresp = 2'b11;
               end else if (idx_of(ra) == 0) begin
                  exp_rdata = IDV; exp_rresp = 2'b00;
               end else begin
                  exp_rdata = model[idx_of(ra)]; exp_rresp = 2'b00;
               end
            end
         end
         if (rvalid) begin
            chk32("rdata", rdata, exp_rdata);
            chk32("rresp", 32'(rresp), 32'(exp_rresp));
         end
         if (bvalid && !prev_b) begin
            chk32("b_has_request", 32'(wq.size() > 0), 32'd1);
            if (wq.size() > 0) begin
               cw = wq.pop_front();
               if (!in_win(cw.addr)) exp_bresp = 2'b11;
               else if (idx_of(cw.addr) == 0) exp_bresp = 2'b10;
               else begin
                  exp_bresp = 2'b00;
                  ix = idx_of(cw.addr);
                  exp_pulse[ix] = 1'b1;
                  for (int k = 0; k < 4; k++)
                     if (cw.strb[k]) model[ix][8*k +: 8] = cw.data[8*k +: 8];
               end
            end
         end
         if (bvalid) chk32("bresp", 32'(bresp), 32'(exp_bresp));
         chk32("pulse", 32'(reg_wr_pulse), 32'(exp_pulse));
         chkw("reg_q", reg_q, model_flat());
         prev_r = rvalid;
         prev_b = bvalid;
      end
   end

   task automatic drv_aw(input logic [31:0] a, input int dly);
      logic hs = 1'b0;
      int   n  = 0;
      repeat (dly + 1) @(posedge clk);
      #1 awaddr = a; awvalid = 1'b1; awprot = 3'($urandom);
      while (!hs && n < 100) begin @(negedge clk); hs = awready; @(posedge clk); n++; end
      #1 awvalid = 1'b0;
      chk32("aw_accepted", 32'(hs), 32'd1);
   endtask

   task automatic drv_w(input logic [31:0] d, input logic [3:0] s, input int dly);
      logic hs = 1'b0;
      int   n  = 0;
      repeat (dly + 1) @(posedge clk);
      #1 wdata = d; wstrb = s; wvalid = 1'b1;
      while (!hs && n < 100) begin @(negedge clk); hs = wready; @(posedge clk); n++; end
      #1 wvalid = 1'b0;
      chk32("w_accepted", 32'(hs), 32'd1);
   endtask

   task automatic drv_ar(input logic [31:0] a, input int dly);
      logic hs = 1'b0;
      int   n  = 0;
      repeat (dly + 1) @(posedge clk);
      #1 araddr = a; arvalid = 1'b1; arprot = 3'($urandom);
      while (!hs && n < 100) begin @(negedge clk); hs = arready; @(posedge clk); n++; end
      #1 arvalid = 1'b0;
      chk32("ar_accepted", 32'(hs), 32'd1);
   endtask

   task automatic drv_b(input int dly);
      logic hs = 1'b0;
      int   n  = 0;
      repeat (dly) @(posedge clk);
      #1 bready = 1'b1;
      while (!hs && n < 100) begin @(negedge clk); hs = bvalid; @(posedge clk); n++; end
      #1 bready = 1'b0;
      chk32("b_seen", 32'(hs), 32'd1);
   endtask

   task automatic drv_r(input int dly);
      logic hs = 1'b0;
      int   n  = 0;
      repeat (dly) @(posedge clk);
      #1 rready = 1'b1;
      while (!hs && n < 100) begin @(negedge clk); hs = rvalid; @(posedge clk); n++; end
      #1 rready = 1'b0;
      chk32("r_seen", 32'(hs), 32'd1);
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int awd, input int wd, input int bd);
      wq.push_back('{addr: a, data: d, strb: s});
      fork
         drv_aw(a, awd);
         drv_w(d, s, wd);
      join
      drv_b(bd);
   endtask

   task automatic do_read(input logic [31:0] a, input int ard, input int rd);
      rq.push_back(a);
      drv_ar(a, ard);
      drv_r(rd);
   endtask

   function automatic logic [31:0] rand_addr();
      if ($urandom_range(0, 9) == 0) return $urandom;
      return BASE + 32'($urandom_range(0, NR * 4 + 11));
   endfunction

   logic [RW-1:0] snap;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, checks %0d", n_chk);
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b0; rready = 1'b0;
      wdata = '0; wstrb = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk32("ready_before_edge", 32'({awready, wready, arready}), 32'd0);
      @(negedge clk);
      chk32("ready_after_edge", 32'({awready, wready, arready}), 32'b111);

      // Same-cycle AW/W: bvalid and pulse one edge after the handshake
      fork
         do_write(BASE + 32'h8, 32'hCAFE_F00D, 4'hF, 0, 0, 0);
         begin
            repeat (2) @(posedge clk);
            @(negedge clk);
            chk32("t1_bvalid_early", 32'(bvalid), 32'd0);
            @(negedge clk);
            chk32("t1_bvalid", 32'(bvalid), 32'd1);
            chk32("t1_bresp", 32'(bresp), 32'd0);
            chk32("t1_pulse", 32'(reg_wr_pulse), 32'h0004);
            chk32("t1_reg2", reg_q[95:64], 32'hCAFE_F00D);
            @(negedge clk);
            chk32("t1_pulse_gone", 32'(reg_wr_pulse), 32'h0000);
         end
      join

      // W leads AW by three cycles
      fork
         do_write(BASE + 32'h4, 32'h1122_3344, 4'h5, 3, 0, 0);
         begin
            repeat (2) @(posedge clk);
            @(negedge clk);
            chk32("t2_wready_low", 32'(wready), 32'd0);
            chk32("t2_awready_high", 32'(awready), 32'd1);
         end
      join
      chk32("t2_reg1", reg_q[63:32], 32'h0022_0044);

      // ID register: write gives SLVERR, read returns ID_VALUE
      fork
         do_write(BASE, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
         begin
            repeat (2) @(posedge clk);
            @(negedge clk);
            @(negedge clk);
            chk32("t3_bresp_slverr", 32'(bresp), 32'b10);
            chk32("t3_no_pulse", 32'(reg_wr_pulse), 32'd0);
         end
      join
      fork
         do_read(BASE, 0, 1);
         begin
            repeat (2) @(posedge clk);
            @(negedge clk);
            chk32("t3_rvalid", 32'(rvalid), 32'd1);
            chk32("t3_rdata_id", rdata, 32'h5A11_0001);
            chk32("t3_rresp", 32'(rresp), 32'd0);
         end
      join

      // Out-of-window read and write
      snap = reg_q;
      fork
         do_read(BASE + 32'(NR * 4), 0, 1);
         begin
            repeat (2) @(posedge clk);
            @(negedge clk);
            chk32("t4_rresp_decerr", 32'(rresp), 32'b11);
            chk32("t4_rdata_zero", rdata, 32'd0);
         end
      join
      fork
         do_write(BASE + 32'(NR * 4), 32'hDEAD_BEEF, 4'hF, 0, 0, 0);
         begin
            repeat (2) @(posedge clk);
            @(negedge clk);
            @(negedge clk);
            chk32("t4_bresp_decerr", 32'(bresp), 32'b11);
         end
      join
      chkw("t4_regs_unchanged", reg_q, snap);

      // Stalled read while a write to reg 3 completes
      fork
         do_read(BASE + 32'h8, 0, 6);
         do_write(BASE + 32'hC, 32'h0BAD_BEEF, 4'hF, 1, 2, 0);
         begin
            repeat (2) @(posedge clk);
            repeat (4) begin
               @(negedge clk);
               chk32("t5_rvalid_held", 32'(rvalid), 32'd1);
               chk32("t5_arready_low", 32'(arready), 32'd0);
               chk32("t5_rdata_held", rdata, 32'hCAFE_F00D);
            end
         end
      join
      chk32("t5_reg3", reg_q[127:96], 32'h0BAD_BEEF);

      // Read and write commit to reg 5 on the same edge: read sees the old value
      fork
         do_write(BASE + 32'h14, 32'h1234_5678, 4'hF, 0, 0, 0);
         do_read(BASE + 32'h14, 1, 0);
         begin
            repeat (2) @(posedge clk);
            @(negedge clk);
            @(negedge clk);
            chk32("t6_read_old", rdata, 32'd0);
            chk32("t6_reg5_new", reg_q[191:160], 32'h1234_5678);
         end
      join

      // Randomized independent read and write traffic
      fork
         for (int i = 0; i < 200; i++)
            do_write(rand_addr(), $urandom, 4'($urandom_range(0, 15)),
                     $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
         for (int i = 0; i < 200; i++)
            do_read(rand_addr(), $urandom_range(0, 3), $urandom_range(0, 3));
      join

      // Reset with B and R both pending
      wq.push_back('{addr: BASE + 32'h10, data: 32'hAAAA_5555, strb: 4'hF});
      rq.push_back(BASE + 32'h4);
      fork
         drv_aw(BASE + 32'h10, 0);
         drv_w(32'hAAAA_5555, 4'hF, 0);
         drv_ar(BASE + 32'h4, 0);
      join
      @(negedge clk);
      @(negedge clk);
      chk32("t7_bvalid_pending", 32'(bvalid), 32'd1);
      chk32("t7_rvalid_pending", 32'(rvalid), 32'd1);
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk32("t7_bvalid_drop", 32'(bvalid), 32'd0);
      chk32("t7_rvalid_drop", 32'(rvalid), 32'd0);
      chkw("t7_reg_q_cleared", reg_q, RW'(IDV));
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      repeat (10) @(negedge clk);
      chk32("t7_no_stale_b", 32'(bvalid), 32'd0);
      chk32("t7_no_stale_r", 32'(rvalid), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
